imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Sequences and shares the single instruction-memory port between the fetch stage and an auxiliary requester (program loader / debug access). It sits between IF's instruction-address/instruction-data path and the instruction memory. It serializes multi-cycle memory transactions and drives the fetch stall. It also discards data belonging to a fetch that was redirected mid-flight, and aborts transactions the memory never acknowledges.

## Interface
Parameters:
- ACK_TIMEOUT, 16: cycles to wait for M_Ack before aborting; legal range 2..255.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- F_Req  in  1  fetch wants a word; held until F_Valid or F_Flush.
- F_Addr  in  32  fetch word address; bits [1:0] ignored.
- F_Flush  in  1  fetch redirected (Request_Alt_PC); outstanding fetch result must be dropped.
- F_Valid  out  1  one-cycle pulse; F_Data holds the fetched word.
- F_Data  out  32  fetched instruction.
- F_Stall  out  1  to IF STALL; equals F_Req & ~F_Valid.
- A_Req  in  1  aux request; held until A_Valid.
- A_Addr  in  32  aux word address.
- A_Write  in  1  1 = write, 0 = read.
- A_WData  in  32  aux write data.
- A_Valid  out  1  one-cycle pulse; aux transaction complete.
- A_RData  out  32  aux read data; 0 on writes.
- M_Req  out  1  memory request; held until M_Ack.
- M_Addr  out  32  memory address, stable while M_Req.
- M_Write  out  1  write strobe, stable while M_Req.
- M_WData  out  32  write data, stable while M_Req.
- M_Ack  in  1  one-cycle completion; M_RData valid in the same cycle.
- M_RData  in  32  memory read data.
- Err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, FETCH, AUX.
- IDLE:
  - If a request is pending, grant it, latch its address/write/data into M_* and set M_Req.
  - Move to FETCH or AUX. Clear the wait counter.
  - F_Flush in the same cycle as F_Req suppresses that fetch grant.
- FETCH/AUX:
  - Wait counter increments each cycle while M_Req.
  - On M_Ack: drop M_Req, register M_RData into F_Data or A_RData, pulse the matching Valid next cycle, return to IDLE.
- Discard flag:
  - Set by F_Flush while in FETCH.
  - With the flag set, the ack completes the memory cycle but F_Valid stays low and F_Data is unchanged.
  - Flag clears on return to IDLE.
- Timeout: counter reaching ACK_TIMEOUT with no ack →
  - drop M_Req
  - pulse Err
  - pulse the owner's Valid with data 0; F_Valid is suppressed if discarding
  - return to IDLE
- Arbitration with both requests pending in IDLE: fetch wins (see Configuration).
- A_Write transactions always return A_RData = 0.
- Back-to-back: IDLE re-grant happens the cycle after the Valid pulse; no combinational path from M_Ack to M_Req.

## Timing
- Reset values: state IDLE; M_Req, M_Write, F_Valid, A_Valid, Err, discard flag, wait counter = 0; M_Addr, M_WData, F_Data, A_RData = 0.
- Request seen in IDLE at cycle N → M_Req high at N+1.
- M_Ack at cycle K → M_Req low at K+1, Valid pulse at K+1, IDLE at K+1.
- Minimum round trip with 1-cycle memory: F_Req at N, F_Valid at N+2.
- RESET mid-transaction: M_Req low next cycle; pending results lost; no Valid or Err pulses.
- F_Flush and M_Ack in the same cycle: data dropped.
- M_Ack in the same cycle the counter hits ACK_TIMEOUT: the ack wins; no Err.
- M_Ack in IDLE is ignored.
- F_Stall is combinational from F_Req and registered F_Valid.

## Configuration
- IMEM_ARB_FAIR_EN defined: round-robin arbitration.
  - A last-grant bit is set on an aux grant and cleared on a fetch grant.
  - With both requests pending, the requester not granted last wins.
- IMEM_ARB_FAIR_EN undefined: fixed priority, fetch over aux; the last-grant bit is absent.

## Structure
- Shared package holds:
  - state encoding constants (IDLE = 2'd0, FETCH = 2'd1, AUX = 2'd2)
  - the default ACK_TIMEOUT
  - the 32-bit word width
- Single module; the wait counter is small enough to stay inline, no sub-module.

## Test plan
- Fetch-only, 1-cycle memory:
  - F_Req at cycle 2, F_Addr = 0xBFC00000 → M_Req at 3 with M_Addr = 0xBFC00000.
  - Ack at 3 with M_RData = 0x24080001 → F_Valid at 4 with F_Data = 0x24080001.
  - F_Stall high in cycles 2–3.
- Flush mid-flight, 3-cycle memory: F_Flush one cycle after grant → ack consumed, no F_Valid, next fetch address 0xBFC00100 issued after IDLE.
- Both requesting in IDLE:
  - Default build: fetch granted.
  - IMEM_ARB_FAIR_EN after one fetch grant: aux granted next, with A_Write = 1, A_Addr = 0x10, A_WData = 0xDEADBEEF on M_*.
- Timeout with ACK_TIMEOUT = 4 and no ack → Err and F_Valid pulse together, F_Data = 0, M_Req low, state IDLE.
- RESET high for 1 cycle during AUX → M_Req low next cycle, no A_Valid, and a fresh F_Req proceeds normally.
- Flush and ack coincide → no F_Valid, F_Data keeps its previous value.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: state encoding,
// default ack timeout and word width.
package imem_port_arbiter_pkg;

  localparam int WORD_W          = 32;
  localparam int ACK_TIMEOUT_DEF = 16;
  localparam int WAIT_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    AUX   = 2'd2
  } arb_state_t;

  // Registered memory-side request; held stable for the whole transaction.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              write;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch and an aux requester.
// Optional round-robin arbitration is enabled by defining IMEM_ARB_FAIR_EN.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              F_Req,
  input  logic [WORD_W-1:0] F_Addr,
  input  logic              F_Flush,
  output logic              F_Valid,
  output logic [WORD_W-1:0] F_Data,
  output logic              F_Stall,
  input  logic              A_Req,
  input  logic [WORD_W-1:0] A_Addr,
  input  logic              A_Write,
  input  logic [WORD_W-1:0] A_WData,
  output logic              A_Valid,
  output logic [WORD_W-1:0] A_RData,
  output logic              M_Req,
  output logic [WORD_W-1:0] M_Addr,
  output logic              M_Write,
  output logic [WORD_W-1:0] M_WData,
  input  logic              M_Ack,
  input  logic [WORD_W-1:0] M_RData,
  output logic              Err
);

  arb_state_t            state, state_d;
  mem_req_t              mreq, mreq_d;
  logic                  m_req_d;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic                  discard, discard_d;
  logic                  f_valid_d, a_valid_d, err_d;
  logic [WORD_W-1:0]     f_data_d, a_rdata_d;
  logic                  f_elig, a_elig, grant_f, grant_a;
  logic                  timed_out, drop_f;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^F_Addr[1:0];

  assign M_Addr  = mreq.addr;
  assign M_Write = mreq.write;
  assign M_WData = mreq.wdata;
  assign F_Stall = F_Req & ~F_Valid;

  // A requester still sees its own Valid pulse this cycle, so its Req is stale.
  assign f_elig = F_Req & ~F_Flush & ~F_Valid;
  assign a_elig = A_Req & ~A_Valid;

`ifdef IMEM_ARB_FAIR_EN
  logic last_aux, last_aux_d;
  assign grant_f = f_elig & (~a_elig | last_aux);
`else
  assign grant_f = f_elig;
`endif
  assign grant_a = a_elig & ~grant_f;

  assign timed_out = (wait_cnt == WAIT_CNT_W'(ACK_TIMEOUT)) & ~M_Ack;
  // A flush arriving together with the ack still drops the data.
  assign drop_f    = discard | F_Flush;

  always_comb begin
    state_d    = state;
    mreq_d     = mreq;
    m_req_d    = M_Req;
    wait_cnt_d = wait_cnt;
    discard_d  = discard;
    f_valid_d  = 1'b0;
    a_valid_d  = 1'b0;
    err_d      = 1'b0;
    f_data_d   = F_Data;
    a_rdata_d  = A_RData;
`ifdef IMEM_ARB_FAIR_EN
    last_aux_d = last_aux;
`endif
    case (state)
      IDLE: begin
        wait_cnt_d = '0;
        discard_d  = 1'b0;
        if (grant_f) begin
          mreq_d  = '{addr: {F_Addr[WORD_W-1:2], 2'b00}, write: 1'b0, wdata: '0};
          m_req_d = 1'b1;
          state_d = FETCH;
`ifdef IMEM_ARB_FAIR_EN
          last_aux_d = 1'b0;
`endif
        end else if (grant_a) begin
          mreq_d  = '{addr: A_Addr, write: A_Write, wdata: A_WData};
          m_req_d = 1'b1;
          state_d = AUX;
`ifdef IMEM_ARB_FAIR_EN
          last_aux_d = 1'b1;
`endif
        end
      end
      FETCH: begin
        wait_cnt_d = wait_cnt + 1'b1;
        if (F_Flush) discard_d = 1'b1;
        if (M_Ack || timed_out) begin
          m_req_d      = 1'b0;
          mreq_d.write = 1'b0;
          discard_d    = 1'b0;
          state_d      = IDLE;
          err_d        = timed_out;
          if (!drop_f) begin
            f_valid_d = 1'b1;
            f_data_d  = M_Ack ? M_RData : '0;
          end
        end
      end
      AUX: begin
        wait_cnt_d = wait_cnt + 1'b1;
        if (M_Ack || timed_out) begin
          m_req_d      = 1'b0;
          mreq_d.write = 1'b0;
          state_d      = IDLE;
          err_d        = timed_out;
          a_valid_d    = 1'b1;
          a_rdata_d    = (M_Ack && !mreq.write) ? M_RData : '0;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      mreq     <= '0;
      M_Req    <= 1'b0;
      wait_cnt <= '0;
      discard  <= 1'b0;
      F_Valid  <= 1'b0;
      A_Valid  <= 1'b0;
      Err      <= 1'b0;
      F_Data   <= '0;
      A_RData  <= '0;
`ifdef IMEM_ARB_FAIR_EN
      last_aux <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      mreq     <= mreq_d;
      M_Req    <= m_req_d;
      wait_cnt <= wait_cnt_d;
      discard  <= discard_d;
      F_Valid  <= f_valid_d;
      A_Valid  <= a_valid_d;
      Err      <= err_d;
      F_Data   <= f_data_d;
      A_RData  <= a_rdata_d;
`ifdef IMEM_ARB_FAIR_EN
      last_aux <= last_aux_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter (ACK_TIMEOUT = 4).
// Expected arbitration order follows IMEM_ARB_FAIR_EN when it is defined.
module tb_imem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        F_Req, F_Flush, F_Valid, F_Stall;
  logic [31:0] F_Addr, F_Data;
  logic        A_Req, A_Write, A_Valid;
  logic [31:0] A_Addr, A_WData, A_RData;
  logic        M_Req, M_Write, M_Ack, Err;
  logic [31:0] M_Addr, M_WData, M_RData;

  int n_chk  = 0;
  int n_fail = 0;

  imem_port_arbiter #(.ACK_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .F_Req(F_Req), .F_Addr(F_Addr), .F_Flush(F_Flush), .F_Valid(F_Valid),
    .F_Data(F_Data), .F_Stall(F_Stall),
    .A_Req(A_Req), .A_Addr(A_Addr), .A_Write(A_Write), .A_WData(A_WData),
    .A_Valid(A_Valid), .A_RData(A_RData),
    .M_Req(M_Req), .M_Addr(M_Addr), .M_Write(M_Write), .M_WData(M_WData),
    .M_Ack(M_Ack), .M_RData(M_RData), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; F_Req = 0; F_Addr = 0; F_Flush = 0;
    A_Req = 0; A_Addr = 0; A_Write = 0; A_WData = 0; M_Ack = 0; M_RData = 0;
    tick; tick;
    n_chk++; if ({M_Req, M_Write, F_Valid, A_Valid, Err, F_Stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {M_Req, M_Write, F_Valid, A_Valid, Err, F_Stall}); end
    n_chk++; if ({M_Addr, M_WData, F_Data, A_RData} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {M_Addr, M_WData, F_Data, A_RData}); end
    RESET = 1'b0;
    tick;
  endtask

  task automatic test_fetch_basic;
    F_Req = 1; F_Addr = 32'hBFC00000;
    #1;
    n_chk++; if (F_Stall !== 1'b1) begin n_fail++; $display("FAIL basic_stall_c2: got %b expected 1", F_Stall); end
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'hBFC00000 || M_Write !== 1'b0) begin
      n_fail++; $display("FAIL basic_mreq: got req=%b addr=%h wr=%b expected 1 bfc00000 0", M_Req, M_Addr, M_Write); end
    n_chk++; if (F_Stall !== 1'b1 || F_Valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_stall_c3: got stall=%b valid=%b expected 1 0", F_Stall, F_Valid); end
    M_Ack = 1; M_RData = 32'h24080001;
    tick;
    M_Ack = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h24080001 || M_Req !== 1'b0) begin
      n_fail++; $display("FAIL basic_valid: got v=%b d=%h mreq=%b expected 1 24080001 0", F_Valid, F_Data, M_Req); end
    n_chk++; if (F_Stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall_c4: got %b expected 0", F_Stall); end
    F_Req = 0;
    tick;
    n_chk++; if (F_Valid !== 1'b0 || M_Req !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: got v=%b mreq=%b expected 0 0", F_Valid, M_Req); end
  endtask

  task automatic test_back_to_back;
    F_Req = 1; F_Addr = 32'h00001000;
    tick;
    M_Ack = 1; M_RData = 32'h11111111;
    tick;
    M_Ack = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h11111111) begin
      n_fail++; $display("FAIL b2b_first: got v=%b d=%h expected 1 11111111", F_Valid, F_Data); end
    F_Addr = 32'h00002003;
    tick;
    n_chk++; if (M_Req !== 1'b0) begin n_fail++; $display("FAIL b2b_no_stale_grant: got %b expected 0", M_Req); end
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h00002000) begin
      n_fail++; $display("FAIL b2b_regrant: got req=%b addr=%h expected 1 00002000", M_Req, M_Addr); end
    M_Ack = 1; M_RData = 32'h22222222;
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h22222222) begin
      n_fail++; $display("FAIL b2b_second: got v=%b d=%h expected 1 22222222", F_Valid, F_Data); end
    tick;
  endtask

  task automatic test_flush;
    F_Req = 1; F_Addr = 32'hBFC00040;
    tick;
    F_Flush = 1; F_Addr = 32'hBFC00100;
    tick;
    F_Flush = 0;
    tick;
    n_chk++; if (M_Req !== 1'b1) begin n_fail++; $display("FAIL flush_hold: got %b expected 1", M_Req); end
    M_Ack = 1; M_RData = 32'h55555555;
    tick;
    M_Ack = 0;
    n_chk++; if (F_Valid !== 1'b0 || F_Data !== 32'h22222222 || M_Req !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got v=%b d=%h mreq=%b expected 0 22222222 0", F_Valid, F_Data, M_Req); end
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'hBFC00100) begin
      n_fail++; $display("FAIL flush_next: got req=%b addr=%h expected 1 bfc00100", M_Req, M_Addr); end
    M_Ack = 1; M_RData = 32'h66666666;
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h66666666) begin
      n_fail++; $display("FAIL flush_next_data: got v=%b d=%h expected 1 66666666", F_Valid, F_Data); end
    tick;
  endtask

  task automatic test_flush_ack;
    F_Req = 1; F_Addr = 32'h00000800;
    tick;
    F_Flush = 1; F_Req = 0; M_Ack = 1; M_RData = 32'h77777777;
    tick;
    F_Flush = 0; M_Ack = 0;
    n_chk++; if (F_Valid !== 1'b0 || F_Data !== 32'h66666666 || M_Req !== 1'b0) begin
      n_fail++; $display("FAIL flush_ack: got v=%b d=%h mreq=%b expected 0 66666666 0", F_Valid, F_Data, M_Req); end
    tick;
  endtask

  task automatic test_flush_idle;
    F_Req = 1; F_Flush = 1; F_Addr = 32'h00000600;
    tick;
    n_chk++; if (M_Req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_suppress: got %b expected 0", M_Req); end
    F_Flush = 0;
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h00000600) begin
      n_fail++; $display("FAIL flush_idle_grant: got req=%b addr=%h expected 1 00000600", M_Req, M_Addr); end
    M_Ack = 1; M_RData = 32'h00000060;
    tick;
    M_Ack = 0; F_Req = 0;
    tick;
  endtask

  task automatic test_arb;
    F_Req = 1; F_Addr = 32'h00000300;
    A_Req = 1; A_Addr = 32'h10; A_Write = 1; A_WData = 32'hDEADBEEF;
    tick;
`ifdef IMEM_ARB_FAIR_EN
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h10 || M_Write !== 1'b1 || M_WData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL arb_first_aux: got req=%b a=%h w=%b d=%h expected 1 10 1 deadbeef", M_Req, M_Addr, M_Write, M_WData); end
    M_Ack = 1; M_RData = 32'h12345678;
    tick;
    A_Req = 0;
    n_chk++; if (A_Valid !== 1'b1 || A_RData !== 32'h0 || F_Valid !== 1'b0) begin
      n_fail++; $display("FAIL arb_aux_done: got av=%b rd=%h fv=%b expected 1 0 0", A_Valid, A_RData, F_Valid); end
    M_RData = 32'h88888888;
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h300 || M_Write !== 1'b0) begin
      n_fail++; $display("FAIL arb_second_fetch: got req=%b a=%h w=%b expected 1 300 0", M_Req, M_Addr, M_Write); end
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h88888888) begin
      n_fail++; $display("FAIL arb_fetch_done: got v=%b d=%h expected 1 88888888", F_Valid, F_Data); end
`else
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h300 || M_Write !== 1'b0) begin
      n_fail++; $display("FAIL arb_first_fetch: got req=%b a=%h w=%b expected 1 300 0", M_Req, M_Addr, M_Write); end
    M_Ack = 1; M_RData = 32'h88888888;
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h88888888 || A_Valid !== 1'b0) begin
      n_fail++; $display("FAIL arb_fetch_done: got fv=%b d=%h av=%b expected 1 88888888 0", F_Valid, F_Data, A_Valid); end
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h10 || M_Write !== 1'b1 || M_WData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL arb_second_aux: got req=%b a=%h w=%b d=%h expected 1 10 1 deadbeef", M_Req, M_Addr, M_Write, M_WData); end
    M_Ack = 1; M_RData = 32'h12345678;
    tick;
    M_Ack = 0; A_Req = 0;
    n_chk++; if (A_Valid !== 1'b1 || A_RData !== 32'h0) begin
      n_fail++; $display("FAIL arb_aux_done: got v=%b rd=%h expected 1 0", A_Valid, A_RData); end
`endif
    M_Ack = 0; A_Write = 0;
    tick;
  endtask

  task automatic test_aux_read;
    A_Req = 1; A_Addr = 32'h20; A_Write = 0;
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h20 || M_Write !== 1'b0) begin
      n_fail++; $display("FAIL aux_rd_req: got req=%b a=%h w=%b expected 1 20 0", M_Req, M_Addr, M_Write); end
    tick;
    n_chk++; if (A_Valid !== 1'b0 || M_Req !== 1'b1) begin
      n_fail++; $display("FAIL aux_rd_wait: got v=%b req=%b expected 0 1", A_Valid, M_Req); end
    M_Ack = 1; M_RData = 32'hCAFEF00D;
    tick;
    M_Ack = 0; A_Req = 0;
    n_chk++; if (A_Valid !== 1'b1 || A_RData !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL aux_rd_done: got v=%b rd=%h expected 1 cafef00d", A_Valid, A_RData); end
    tick;
    n_chk++; if (A_Valid !== 1'b0) begin n_fail++; $display("FAIL aux_rd_pulse: got %b expected 0", A_Valid); end
  endtask

  task automatic test_timeout;
    F_Req = 1; F_Addr = 32'h00000400;
    for (int i = 1; i <= 5; i++) begin
      tick;
      n_chk++; if (M_Req !== 1'b1 || Err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait_%0d: got req=%b err=%b expected 1 0", i, M_Req, Err); end
    end
    tick;
    F_Req = 0;
    n_chk++; if (Err !== 1'b1 || F_Valid !== 1'b1 || F_Data !== 32'h0 || M_Req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort: got err=%b v=%b d=%h req=%b expected 1 1 0 0", Err, F_Valid, F_Data, M_Req); end
    tick;
    n_chk++; if (Err !== 1'b0 || F_Valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got err=%b v=%b expected 0 0", Err, F_Valid); end
  endtask

  task automatic test_ack_at_timeout;
    F_Req = 1; F_Addr = 32'h00000700;
    for (int i = 1; i <= 5; i++) tick;
    M_Ack = 1; M_RData = 32'hABCD0123;
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (Err !== 1'b0 || F_Valid !== 1'b1 || F_Data !== 32'hABCD0123) begin
      n_fail++; $display("FAIL ack_at_timeout: got err=%b v=%b d=%h expected 0 1 abcd0123", Err, F_Valid, F_Data); end
    tick;
  endtask

  task automatic test_reset_mid;
    A_Req = 1; A_Addr = 32'h10; A_Write = 1; A_WData = 32'h5A5A5A5A;
    tick;
    RESET = 1;
    tick;
    RESET = 0; A_Req = 0; A_Write = 0;
    n_chk++; if (M_Req !== 1'b0 || A_Valid !== 1'b0 || Err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got req=%b av=%b err=%b expected 0 0 0", M_Req, A_Valid, Err); end
    tick;
    n_chk++; if (M_Req !== 1'b0 || A_Valid !== 1'b0 || Err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got req=%b av=%b err=%b expected 0 0 0", M_Req, A_Valid, Err); end
    F_Req = 1; F_Addr = 32'h00000500;
    tick;
    n_chk++; if (M_Req !== 1'b1 || M_Addr !== 32'h500) begin
      n_fail++; $display("FAIL rst_fresh_req: got req=%b a=%h expected 1 500", M_Req, M_Addr); end
    M_Ack = 1; M_RData = 32'h00000099;
    tick;
    M_Ack = 0; F_Req = 0;
    n_chk++; if (F_Valid !== 1'b1 || F_Data !== 32'h99) begin
      n_fail++; $display("FAIL rst_fresh_done: got v=%b d=%h expected 1 99", F_Valid, F_Data); end
    tick;
  endtask

  task automatic test_ack_idle;
    M_Ack = 1; M_RData = 32'hFFFFFFFF;
    tick;
    M_Ack = 0;
    n_chk++; if (F_Valid !== 1'b0 || A_Valid !== 1'b0 || M_Req !== 1'b0 || F_Data !== 32'h99 || Err !== 1'b0) begin
      n_fail++; $display("FAIL ack_idle: got fv=%b av=%b req=%b d=%h err=%b expected 0 0 0 99 0", F_Valid, A_Valid, M_Req, F_Data, Err); end
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch_basic;
    test_back_to_back;
    test_flush;
    test_flush_ack;
    test_flush_idle;
    test_arb;
    test_aux_read;
    test_timeout;
    test_ack_at_timeout;
    test_reset_mid;
    test_ack_idle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
